byte_unstriping: RTL and testbench

//  Receive-side counterpart of the byte striper. Accepts one symbol set (one byte + K flag per active lane) per handshake.
//  Re-serialises the set onto a single byte stream in lane order LANE0, LANE1, ...

---
 rtl/byte_unstriping.sv | 207 ++++++++++++++++++++
 tb/tb_byte_unstriping.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_unstriping.sv
// byte_unstriping
//   Receive-side lane unstriper. One symbol set (byte + K flag per active
//   lane) is accepted per handshake and re-serialised onto a single byte
//   stream in lane order LANE0, LANE1, ... A two-state framing FSM tracks
//   STP/SDP .. END/EDB on the rebuilt stream and pulses ERR on misplaced
//   delimiters or data outside a packet.
//
//   Optional feature macro: UNSTRIPE_DROP_FILL_EN
//     defined   : SKP/IDL control bytes consume their slot but are not
//                 emitted (U_VALID=0, ERR=0, PKT_ACTIVE holds).
//     undefined : SKP/IDL are emitted like any other byte.
//
//   Handshake: a set is accepted at a rising edge where IN_VALID & IN_READY.
//   IN_READY is combinational, is low during RESET, and is high whenever at
//   most one buffered byte is still waiting. The last waiting byte is emitted
//   on the same edge that reloads the buffer. The output side has no
//   backpressure.
module byte_unstriping #(
    parameter int LANES = 4,
    parameter int BITS  = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [BITS-1:0] LANE0,
    input  logic [BITS-1:0] LANE1,
    input  logic [BITS-1:0] LANE2,
    input  logic [BITS-1:0] LANE3,
    input  logic            DK_0,
    input  logic            DK_1,
    input  logic            DK_2,
    input  logic            DK_3,
    input  logic            IN_VALID,
    output logic            IN_READY,
    output logic [BITS-1:0] U_D,
    output logic            U_DK,
    output logic            U_VALID,
    output logic            PKT_ACTIVE,
    output logic            ERR,
    output logic            dbg_state
);

    localparam int CW = $clog2(LANES + 1);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [BITS-1:0] K_STP = BITS'(8'hFB);
    localparam logic [BITS-1:0] K_SDP = BITS'(8'h5C);
    localparam logic [BITS-1:0] K_END = BITS'(8'hFD);
    localparam logic [BITS-1:0] K_EDB = BITS'(8'hFE);
    localparam logic [BITS-1:0] K_SKP = BITS'(8'h1C);
    localparam logic [BITS-1:0] K_IDL = BITS'(8'h7C);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PKT  = 1'b1
    } state_t;

    state_t state_q;
    state_t nxt_state;

    // Buffered set: ptr_q walks from lane 0 upwards while cnt_q counts the
    // bytes still to be emitted, so ptr_q == LANES - cnt_q (mod LANES).
    logic [BITS-1:0] buf_d_q [LANES];
    logic            buf_k_q [LANES];
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   ptr_q;

    logic [BITS-1:0] lane_w [4];
    logic            dk_w   [4];
    logic            accept;

    logic [BITS-1:0] sel_d;
    logic            sel_dk;
    logic            is_start;
    logic            is_end;
    logic            is_fill;

    logic [BITS-1:0] em_d;
    logic            em_dk;
    logic            em_valid;
    logic            em_active;
    logic            em_err;

    // Gather the fixed lane ports into arrays so the load loop stays generic.
    always_comb begin
        lane_w[0] = LANE0;
        lane_w[1] = LANE1;
        lane_w[2] = LANE2;
        lane_w[3] = LANE3;
        dk_w[0]   = DK_0;
        dk_w[1]   = DK_1;
        dk_w[2]   = DK_2;
        dk_w[3]   = DK_3;
    end

    assign IN_READY  = !RESET && (cnt_q <= CW'(1));
    assign accept    = IN_VALID && IN_READY;
    assign dbg_state = (state_q == S_PKT);

    // Classify the byte at the head of the buffer.
    always_comb begin
        sel_d    = buf_d_q[ptr_q];
        sel_dk   = buf_k_q[ptr_q];
        is_start = sel_dk && ((sel_d == K_STP) || (sel_d == K_SDP));
        is_end   = sel_dk && ((sel_d == K_END) || (sel_d == K_EDB));
        is_fill  = sel_dk && ((sel_d == K_SKP) || (sel_d == K_IDL));
    end

    // Framing next-state and next output values for the byte being emitted.
    always_comb begin
        nxt_state = state_q;
        em_d      = '0;
        em_dk     = 1'b0;
        em_valid  = 1'b0;
        em_active = 1'b0;
        em_err    = 1'b0;
        if (cnt_q != '0) begin
            em_d     = sel_d;
            em_dk    = sel_dk;
            em_valid = 1'b1;
            if (is_fill) begin
`ifdef UNSTRIPE_DROP_FILL_EN
                // Fill symbol swallowed: slot stays empty, framing untouched.
                em_d      = '0;
                em_dk     = 1'b0;
                em_valid  = 1'b0;
                em_active = PKT_ACTIVE;
`else
                // Fill symbol passes through and never disturbs framing.
                em_active = (state_q == S_PKT);
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (is_start) begin
                            nxt_state = S_PKT;
                            em_active = 1'b1;
                        end else if (is_end) begin
                            em_err = 1'b1;
                        end else if (!sel_dk) begin
                            em_err = 1'b1;
                        end
                    end
                    S_PKT: begin
                        em_active = 1'b1;
                        if (is_start) begin
                            em_err = 1'b1;
                        end else if (is_end) begin
                            nxt_state = S_IDLE;
                        end
                    end
                    default: begin
                        nxt_state = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Framing state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= nxt_state;
        end
    end

    // Buffer load on accept, otherwise step through the held set.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
            ptr_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                buf_d_q[i] <= '0;
                buf_k_q[i] <= 1'b0;
            end
        end else if (accept) begin
            cnt_q <= CW'(LANES);
            ptr_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                buf_d_q[i] <= lane_w[i];
                buf_k_q[i] <= dk_w[i];
            end
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
            ptr_q <= ptr_q + IW'(1);
        end
    end

    // Registered output stage, aligned with the framing decision.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            U_D        <= '0;
            U_DK       <= 1'b0;
            U_VALID    <= 1'b0;
            PKT_ACTIVE <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            U_D        <= em_d;
            U_DK       <= em_dk;
            U_VALID    <= em_valid;
            PKT_ACTIVE <= em_active;
            ERR        <= em_err;
        end
    end

endmodule

// File: tb/tb_byte_unstriping.sv
// tb_byte_unstriping
//   Directed bench for byte_unstriping with LANES=4, BITS=8. Each scenario
//   task drives its own vectors and compares against hand-computed values.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_byte_unstriping;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] LANE0, LANE1, LANE2, LANE3;
    logic       DK_0, DK_1, DK_2, DK_3;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] U_D;
    logic       U_DK;
    logic       U_VALID;
    logic       PKT_ACTIVE;
    logic       ERR;
    logic       dbg_state;

    int errors = 0;
    int checks = 0;

    byte_unstriping #(.LANES(4), .BITS(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .LANE0(LANE0), .LANE1(LANE1), .LANE2(LANE2), .LANE3(LANE3),
        .DK_0(DK_0), .DK_1(DK_1), .DK_2(DK_2), .DK_3(DK_3),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .U_D(U_D), .U_DK(U_DK), .U_VALID(U_VALID),
        .PKT_ACTIVE(PKT_ACTIVE), .ERR(ERR), .dbg_state(dbg_state)
    );

    // Clock: 10 ns period.
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_set(input logic [31:0] d, input logic [3:0] k);
        LANE0 = d[7:0];   LANE1 = d[15:8];
        LANE2 = d[23:16]; LANE3 = d[31:24];
        DK_0 = k[0]; DK_1 = k[1]; DK_2 = k[2]; DK_3 = k[3];
    endtask

    // Present a set and hold it until accepted (bounded wait).
    task automatic send_set(input logic [31:0] d, input logic [3:0] k);
        int waited;
        waited = 0;
        drive_set(d, k);
        IN_VALID = 1'b1;
        while (!IN_READY && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: IN_READY=%b required 1", IN_READY);
        end
        step();
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        IN_VALID = 1'b1;
        drive_set(32'hFD_FF_33_FB, 4'b1001);
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (IN_READY !== 1'b0 || U_VALID !== 1'b0 || U_D !== 8'h00 || U_DK !== 1'b0 ||
                PKT_ACTIVE !== 1'b0 || ERR !== 1'b0 || dbg_state !== 1'b0) begin
                errors++;
                $display("FAIL reset_c%0d: rdy=%b v=%b d=%h dk=%b pa=%b err=%b st=%b required all 0",
                         c, IN_READY, U_VALID, U_D, U_DK, PKT_ACTIVE, ERR, dbg_state);
            end
        end
        IN_VALID = 1'b0;
        RESET = 1'b0;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: IN_READY=%b required 1", IN_READY);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (U_VALID !== 1'b0) begin
                errors++;
                $display("FAIL reset_nothing_captured_c%0d: U_VALID=%b required 0", c, U_VALID);
            end
        end
    endtask

    task automatic test_packet();
        logic [7:0] exp_d [4];
        logic       exp_k [4];
        exp_d = '{8'hFB, 8'h33, 8'hFF, 8'hFD};
        exp_k = '{1'b1, 1'b0, 1'b0, 1'b1};
        send_set(32'hFD_FF_33_FB, 4'b1001);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (U_VALID !== 1'b1 || U_D !== exp_d[i] || U_DK !== exp_k[i] ||
                PKT_ACTIVE !== 1'b1 || ERR !== 1'b0) begin
                errors++;
                $display("FAIL packet_b%0d: v=%b d=%h dk=%b pa=%b err=%b required v=1 d=%h dk=%b pa=1 err=0",
                         i, U_VALID, U_D, U_DK, PKT_ACTIVE, ERR, exp_d[i], exp_k[i]);
            end
        end
        step();
        checks++;
        if (U_VALID !== 1'b0 || dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL packet_tail: v=%b st=%b required v=0 st=0", U_VALID, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [8];
        exp_d = '{8'h5C, 8'h55, 8'h41, 8'hFE, 8'hFB, 8'h33, 8'hFF, 8'hFD};
        drive_set(32'hFE_41_55_5C, 4'b1001);
        IN_VALID = 1'b1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready0: IN_READY=%b required 1", IN_READY);
        end
        step();
        drive_set(32'hFD_FF_33_FB, 4'b1001);
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c == 4) IN_VALID = 1'b0;
            checks++;
            if (U_VALID !== 1'b1 || U_D !== exp_d[c-1] || PKT_ACTIVE !== 1'b1 || ERR !== 1'b0) begin
                errors++;
                $display("FAIL b2b_byte%0d: v=%b d=%h pa=%b err=%b required v=1 d=%h pa=1 err=0",
                         c, U_VALID, U_D, PKT_ACTIVE, ERR, exp_d[c-1]);
            end
            checks++;
            if (IN_READY !== (c == 3 || c == 7 || c == 8)) begin
                errors++;
                $display("FAIL b2b_ready%0d: IN_READY=%b required %b",
                         c, IN_READY, (c == 3 || c == 7 || c == 8));
            end
        end
        step();
        checks++;
        if (U_VALID !== 1'b0 || dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: v=%b st=%b required v=0 st=0", U_VALID, dbg_state);
        end
    endtask

    task automatic test_idle_errors();
        logic [7:0] exp_d [4];
        logic       exp_e [4];
        logic       exp_v [4];
        exp_d = '{8'h33, 8'hFD, 8'h7C, 8'h7C};
        exp_e = '{1'b1, 1'b1, 1'b0, 1'b0};
`ifdef UNSTRIPE_DROP_FILL_EN
        exp_v = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        send_set(32'h7C_7C_FD_33, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (U_VALID !== exp_v[i] || ERR !== exp_e[i] || PKT_ACTIVE !== 1'b0 ||
                (exp_v[i] && U_D !== exp_d[i])) begin
                errors++;
                $display("FAIL idle_err_b%0d: v=%b d=%h err=%b pa=%b required v=%b d=%h err=%b pa=0",
                         i, U_VALID, U_D, ERR, PKT_ACTIVE, exp_v[i], exp_d[i], exp_e[i]);
            end
        end
        checks++;
        if (dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL idle_err_state: st=%b required 0", dbg_state);
        end
    endtask

    task automatic test_pkt_errors();
        logic       exp_e [4];
        exp_e = '{1'b0, 1'b1, 1'b0, 1'b0};
        step();
        send_set(32'hFD_33_FB_FB, 4'b1011);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (U_VALID !== 1'b1 || ERR !== exp_e[i] || PKT_ACTIVE !== 1'b1) begin
                errors++;
                $display("FAIL pkt_err_b%0d: v=%b err=%b pa=%b required v=1 err=%b pa=1",
                         i, U_VALID, ERR, PKT_ACTIVE, exp_e[i]);
            end
        end
        step();
        checks++;
        if (dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL pkt_err_state: st=%b required 0", dbg_state);
        end
    endtask

    task automatic test_fill();
        logic [7:0] exp_d [4];
        logic       exp_v [4];
        exp_d = '{8'hFB, 8'h1C, 8'h33, 8'hFD};
`ifdef UNSTRIPE_DROP_FILL_EN
        exp_v = '{1'b1, 1'b0, 1'b1, 1'b1};
`else
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        send_set(32'hFD_33_1C_FB, 4'b1011);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (U_VALID !== exp_v[i] || ERR !== 1'b0 || PKT_ACTIVE !== 1'b1 ||
                (exp_v[i] && U_D !== exp_d[i])) begin
                errors++;
                $display("FAIL fill_b%0d: v=%b d=%h err=%b pa=%b required v=%b d=%h err=0 pa=1",
                         i, U_VALID, U_D, ERR, PKT_ACTIVE, exp_v[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step();
        send_set(32'hFD_FF_33_FB, 4'b1001);
        step();
        checks++;
        if (U_VALID !== 1'b1 || U_D !== 8'hFB) begin
            errors++;
            $display("FAIL mid_b0: v=%b d=%h required v=1 d=fb", U_VALID, U_D);
        end
        step();
        checks++;
        if (U_VALID !== 1'b1 || U_D !== 8'h33) begin
            errors++;
            $display("FAIL mid_b1: v=%b d=%h required v=1 d=33", U_VALID, U_D);
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        checks++;
        if (U_VALID !== 1'b0 || PKT_ACTIVE !== 1'b0 || dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: v=%b pa=%b st=%b required 0 0 0", U_VALID, PKT_ACTIVE, dbg_state);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (U_VALID !== 1'b0) begin
                errors++;
                $display("FAIL mid_discard_c%0d: U_VALID=%b required 0", c, U_VALID);
            end
        end
        send_set(32'hFD_FF_33_FB, 4'b1001);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (U_VALID !== 1'b1 || ERR !== 1'b0 || PKT_ACTIVE !== 1'b1) begin
                errors++;
                $display("FAIL mid_restart_b%0d: v=%b err=%b pa=%b required v=1 err=0 pa=1",
                         i, U_VALID, ERR, PKT_ACTIVE);
            end
        end
        checks++;
        if (U_D !== 8'hFD) begin
            errors++;
            $display("FAIL mid_restart_last: d=%h required fd", U_D);
        end
    endtask

    initial begin
        RESET = 1'b1;
        IN_VALID = 1'b0;
        drive_set(32'h0, 4'h0);
        test_reset();
        test_packet();
        test_back_to_back();
        test_idle_errors();
        test_pkt_errors();
        test_fill();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
